// File: rtl/axi_arb_pkg.sv
// Shared types for the round-robin AXI write-address arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int QOS_WIDTH_DEF = 4;

endpackage

// File: rtl/axi_rr_wr_arbiter_if.sv
// Write-address / write-response bus between the masters, the arbiter and the downstream slave.
interface axi_rr_wr_arbiter_if import axi_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int QOS_WIDTH   = QOS_WIDTH_DEF
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]            m_awvalid;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr;
  logic [NUM_MASTERS*QOS_WIDTH-1:0]  m_awqos;
  logic [NUM_MASTERS-1:0]            m_awready;
  logic                              s_awvalid;
  logic [ADDR_WIDTH-1:0]             s_awaddr;
  logic                              s_awready;
  logic                              s_bvalid;
  logic                              s_bready;
  logic [IDX_W-1:0]                  grant_id;
  logic                              busy;

  // Environment side: requesting masters plus the downstream slave.
  modport master (
    output m_awvalid, m_awaddr, m_awqos, s_awready, s_bvalid, s_bready,
    input  m_awready, s_awvalid, s_awaddr, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  m_awvalid, m_awaddr, m_awqos, s_awready, s_bvalid, s_bready,
    output m_awready, s_awvalid, s_awaddr, grant_id, busy
  );

endinterface

// File: rtl/axi_rr_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first eligible requester strictly after last_grant, with wrap.
module rr_pick import axi_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   found
);

  logic [NUM_MASTERS-1:0] eff;
  logic [IDX_W:0]         pos;

  // One extra bit on pos so last_grant + offset can exceed NUM_MASTERS before the wrap.
  always_comb begin
    eff   = req & mask;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      pos = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_MASTERS))
        pos = pos - (IDX_W+1)'(NUM_MASTERS);
      if (!found && eff[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_rr_wr_arbiter.sv
// Round-robin AXI write-address arbiter holding ownership from grant to B handshake.
// Define AXI_ARB_QOS_EN to arbitrate on highest m_awqos first, rotating among ties.
module axi_rr_wr_arbiter import axi_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int QOS_WIDTH   = QOS_WIDTH_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_rr_wr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_e             state;
  logic [IDX_W-1:0]       grant_id;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [NUM_MASTERS-1:0] mask;
  logic [NUM_MASTERS-1:0] m_awready;
  logic                   s_awvalid;
  logic [ADDR_WIDTH-1:0]  s_awaddr;
  logic                   busy;

`ifdef AXI_ARB_QOS_EN
  logic [QOS_WIDTH-1:0] max_qos;

  // Only masters sharing the highest requesting QoS stay eligible for the rotation.
  always_comb begin
    max_qos = '0;
    mask    = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (bus.m_awvalid[i] && bus.m_awqos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos)
        max_qos = bus.m_awqos[i*QOS_WIDTH +: QOS_WIDTH];
    for (int i = 0; i < NUM_MASTERS; i++)
      mask[i] = (bus.m_awqos[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
  end
`else
  logic unused_qos;

  assign mask       = '1;
  assign unused_qos = ^bus.m_awqos;
`endif

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req        (bus.m_awvalid),
    .mask       (mask),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      s_awvalid  <= 1'b0;
      s_awaddr   <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      last_grant <= IDX_W'(NUM_MASTERS-1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            s_awaddr  <= bus.m_awaddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_awvalid <= 1'b1;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus.s_awready) begin
            s_awvalid <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          // Rotation pointer advances only once the whole write has completed.
          if (bus.s_bvalid && bus.s_bready) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    m_awready = '0;
    if (state == ADDR && bus.s_awready)
      m_awready[grant_id] = 1'b1;
  end

  assign bus.m_awready = m_awready;
  assign bus.s_awvalid = s_awvalid;
  assign bus.s_awaddr  = s_awaddr;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_axi_rr_wr_arbiter.sv
// Self-checking bench for axi_rr_wr_arbiter: directed steps followed by randomized transactions.
module tb_axi_rr_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int QW = 4;

  logic ACLK = 1'b0;
  logic ARESET;

  always #5 ACLK = ~ACLK;

  axi_rr_wr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .QOS_WIDTH(QW)) bus ();

  axi_rr_wr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .QOS_WIDTH(QW)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int model_last;
  logic [AW-1:0] addr_a [N];
  logic [QW-1:0] qos_a  [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: rotation order starting after the last completed owner, optionally QoS-filtered.
  function automatic int model_pick(input logic [N-1:0] req);
    int best;
    best = 0;
`ifdef AXI_ARB_QOS_EN
    for (int i = 0; i < N; i++)
      if (req[i] && int'(qos_a[i]) > best) best = int'(qos_a[i]);
`endif
    for (int k = 1; k <= N; k++) begin
      int j;
      bit ok;
      j  = (model_last + k) % N;
      ok = req[j];
`ifdef AXI_ARB_QOS_EN
      ok = ok && (int'(qos_a[j]) == best);
`endif
      if (ok) return j;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] req);
    bus.m_awvalid = req;
    for (int i = 0; i < N; i++) begin
      bus.m_awaddr[i*AW +: AW] = addr_a[i];
      bus.m_awqos[i*QW +: QW]  = qos_a[i];
    end
  endtask

  task automatic do_reset();
    ARESET        = 1'b1;
    bus.m_awvalid = '0;
    bus.s_awready = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    model_last = N - 1;
  endtask

  task automatic run_txn(input logic [N-1:0] req, input int hold, output int got);
    int w;
    logic [AW-1:0] a;
    drive(req);
    w = model_pick(req);
    a = addr_a[w];
    #1 chk("idle_awvalid", 64'(bus.s_awvalid), 64'(0));
    @(posedge ACLK); #1;
    chk("grant_id", 64'(bus.grant_id), 64'(w));
    chk("awvalid_set", 64'(bus.s_awvalid), 64'(1));
    chk("awaddr", 64'(bus.s_awaddr), 64'(a));
    chk("busy_addr", 64'(bus.busy), 64'(1));
    got = int'(bus.grant_id);
    bus.m_awaddr[w*AW +: AW] = ~a;
    if ($urandom_range(1, 0) == 1) bus.m_awvalid = '0;
    for (int c = 0; c < hold; c++) begin
      bus.s_bvalid  = 1'($urandom);
      bus.s_bready  = 1'b1;
      bus.m_awvalid = N'($urandom);
      @(posedge ACLK); #1;
      chk("hold_awvalid", 64'(bus.s_awvalid), 64'(1));
      chk("hold_awaddr", 64'(bus.s_awaddr), 64'(a));
      chk("hold_awready", 64'(bus.m_awready), 64'(0));
    end
    bus.s_bvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_awready = 1'b1;
    #1 chk("m_awready", 64'(bus.m_awready), 64'(1) << w);
    @(posedge ACLK); #1;
    bus.s_awready = 1'b0;
    chk("resp_awvalid", 64'(bus.s_awvalid), 64'(0));
    chk("resp_busy", 64'(bus.busy), 64'(1));
    if ($urandom_range(1, 0) == 1) begin
      bus.s_bvalid  = 1'b1;
      bus.m_awvalid = N'($urandom);
      @(posedge ACLK); #1;
      chk("resp_wait_busy", 64'(bus.busy), 64'(1));
    end
    bus.s_bvalid = 1'b1;
    bus.s_bready = 1'b1;
    @(posedge ACLK); #1;
    bus.s_bvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.m_awvalid = '0;
    chk("done_busy", 64'(bus.busy), 64'(0));
    model_last = w;
  endtask

  initial begin
    int g;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(32'h100 * (i + 1));
      qos_a[i]  = '0;
    end
    do_reset();
    chk("rst_awvalid", 64'(bus.s_awvalid), 64'(0));
    chk("rst_awaddr", 64'(bus.s_awaddr), 64'(0));
    chk("rst_awready", 64'(bus.m_awready), 64'(0));
    chk("rst_grant", 64'(bus.grant_id), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));

    // Single master 0 request.
    addr_a[0] = 32'h0000_0010;
    run_txn(4'b0001, 0, g);
    chk("m0_only", 64'(g), 64'(0));

    // Two masters requesting continuously alternate.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      run_txn(4'b0011, $urandom_range(2, 0), g);
      chk("alt_seq", 64'(g), 64'(t % 2));
    end

    // Sparse requests wrap past the top master.
    do_reset();
    run_txn(4'b1010, 1, g);
    chk("wrap_first", 64'(g), 64'(1));
    run_txn(4'b1010, 0, g);
    chk("wrap_second", 64'(g), 64'(3));
    run_txn(4'b1010, 0, g);
    chk("wrap_third", 64'(g), 64'(1));

    // Slave stalls for ten cycles.
    run_txn(4'b0100, 10, g);

    // Idle with no requests.
    repeat (3) @(posedge ACLK);
    #1 chk("idle_busy", 64'(bus.busy), 64'(0));

    // Reset while waiting for the write response.
    run_txn(4'b0100, 0, g);
    drive(4'b1000);
    @(posedge ACLK); #1 bus.s_awready = 1'b1;
    @(posedge ACLK); #1 bus.s_awready = 1'b0;
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    bus.m_awvalid = '0;
    ARESET = 1'b1;
    @(posedge ACLK); #1 ARESET = 1'b0;
    model_last = N - 1;
    chk("resp_rst_busy", 64'(bus.busy), 64'(0));
    chk("resp_rst_awvalid", 64'(bus.s_awvalid), 64'(0));
    chk("resp_rst_grant", 64'(bus.grant_id), 64'(0));
    run_txn(4'b1111, 0, g);
    chk("after_rst_grant", 64'(g), 64'(0));

    // Reset in ADDR with the slave accepting on the same edge.
    drive(4'b0010);
    @(posedge ACLK); #1;
    bus.m_awvalid = '0;
    bus.s_awready = 1'b1;
    ARESET        = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    model_last = N - 1;
    chk("addr_rst_awready", 64'(bus.m_awready), 64'(0));
    chk("addr_rst_awvalid", 64'(bus.s_awvalid), 64'(0));
    bus.s_awready = 1'b0;

    // QoS preference and tie rotation.
    do_reset();
    qos_a[0] = 4'd2;
    qos_a[1] = 4'd9;
    run_txn(4'b0011, 0, g);
`ifdef AXI_ARB_QOS_EN
    chk("qos_high_first", 64'(g), 64'(1));
`else
    chk("qos_ignored", 64'(g), 64'(0));
`endif
    qos_a[0] = 4'd5;
    qos_a[1] = 4'd5;
    run_txn(4'b0011, 0, g);
    run_txn(4'b0011, 0, g);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        addr_a[i] = AW'($urandom);
        qos_a[i]  = QW'($urandom_range(3, 0));
      end
      run_txn(N'($urandom_range(15, 1)), $urandom_range(3, 0), g);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_rr_wr_arbiter.md
AXI_RR_WR_ARBITER -- requirements
Module: axi_rr_wr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of requesting masters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, AW address width.
REQ-003 Parameter QOS_WIDTH, default 4, per-master QoS field width.
REQ-004 ACLK  input  1  single clock; all logic rising-edge.
REQ-005 ARESET  input  1  reset, synchronous, active-high.
REQ-006 m_awvalid  input  NUM_MASTERS  per-master write-address request.
REQ-007 m_awaddr  input  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at slice i.
REQ-008 m_awqos  input  NUM_MASTERS*QOS_WIDTH  per-master QoS, master i at slice i.
REQ-009 m_awready  output  NUM_MASTERS  one-hot acceptance to granted master.
REQ-010 s_awvalid  output  1  downstream address valid.
REQ-011 s_awaddr  output  ADDR_WIDTH  downstream address, registered.
REQ-012 s_awready  input  1  downstream address accept.
REQ-013 s_bvalid, s_bready  input  1 each  downstream write-response handshake observed.
REQ-014 grant_id  output  clog2(NUM_MASTERS)  index of current owner.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, ADDR, RESP; transaction lock from grant until B handshake.
REQ-017 IDLE: if any m_awvalid high, choose winner, latch grant_id and address, go ADDR next edge.
REQ-018 Winner = first requester strictly after last_grant, scanning upward with wrap modulo NUM_MASTERS.
REQ-019 ADDR: s_awvalid=1, s_awaddr held stable; on s_awready=1, pulse m_awready[grant_id] for that same cycle, go RESP.
REQ-020 m_awready combinational = s_awready in ADDR, one-hot on grant_id, zero otherwise.
REQ-021 RESP: on s_bvalid&&s_bready, set last_grant=grant_id, return IDLE.
REQ-022 Minimum request-to-s_awvalid latency 1 cycle; back-to-back grants separated by 1 IDLE cycle.
REQ-023 Requests arriving in ADDR/RESP ignored until IDLE; no request queueing.
REQ-024 Simultaneous requests from all masters served in strict rotation, each within NUM_MASTERS transactions.
REQ-025 m_awvalid of owner dropping during ADDR does not abort; address already latched is issued.
REQ-026 s_bvalid&&s_bready in IDLE or ADDR ignored.

Reset
REQ-027 On ARESET: state=IDLE, s_awvalid=0, s_awaddr=0, m_awready=0, grant_id=0, busy=0, last_grant=NUM_MASTERS-1 (master 0 first).
REQ-028 ARESET mid-transaction abandons it in the same edge; no m_awready pulse afterwards.

Configuration
REQ-029 Macro AXI_ARB_QOS_EN defined: winner = highest m_awqos among requesters; ties resolved by REQ-018 rotation among tied masters.
REQ-030 Macro undefined: m_awqos ignored, pure round-robin per REQ-018, no QoS comparator logic synthesised.

Structure
REQ-031 Shared package axi_arb_pkg holds state enum (IDLE/ADDR/RESP) and QOS_WIDTH default constant.
REQ-032 One sub-module rr_pick: combinational rotate-and-priority-encode given request vector, mask, last_grant; returns index and found flag.
REQ-033 Target 150-300 lines total RTL.

Verification
REQ-034 Reset, m_awvalid=2'b01, addr 0x0000_0010 -> s_awvalid at cycle+1, s_awaddr=0x10, grant_id=0, m_awready=01 on s_awready.
REQ-035 Both masters request continuously, 4 transactions, no QoS -> grant_id sequence 0,1,0,1.
REQ-036 NUM_MASTERS=4, requests 4'b1010 after last_grant=3 -> grant 1 then 3; wrap verified.
REQ-037 AXI_ARB_QOS_EN, m0 qos=2, m1 qos=9, both request -> master 1 granted first; equal qos 5/5 -> rotation.
REQ-038 ARESET asserted in RESP -> next cycle state IDLE, busy=0, s_awvalid=0, last_grant=NUM_MASTERS-1.
REQ-039 s_awready held low 10 cycles -> s_awvalid and s_awaddr stable throughout, m_awready all zero.
